// File: rtl/ex_muldiv_if.sv
// ID/EX to multiply/divide unit bundle.
// master = pipeline side, slave = the HI/LO unit.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             valid_in;
    logic [3:0]       op_type;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output valid_in, op_type, operand_a, operand_b, flush,
        input  stall, busy, result, result_valid, hi, lo
    );

    modport slave (
        input  valid_in, op_type, operand_a, operand_b, flush,
        output stall, busy, result, result_valid, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning HI/LO.
// Shift-add multiply and restoring divide on operand magnitudes.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        reset,
    ex_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;

    logic op_mul, op_div, op_sgn;
    logic op_mfhi, op_mflo, op_mthi, op_mtlo;

    always_comb begin
        op_mul  = 1'b0;
        op_div  = 1'b0;
        op_sgn  = 1'b0;
        op_mfhi = 1'b0;
        op_mflo = 1'b0;
        op_mthi = 1'b0;
        op_mtlo = 1'b0;
        case (bus.op_type)
            4'h1: begin op_mul = 1'b1; op_sgn = 1'b1; end
            4'h2: op_mul = 1'b1;
            4'h3: begin op_div = 1'b1; op_sgn = 1'b1; end
            4'h4: op_div = 1'b1;
            4'h5: op_mfhi = 1'b1;
            4'h6: op_mflo = 1'b1;
            4'h7: op_mthi = 1'b1;
            4'h8: op_mtlo = 1'b1;
            default: ;
        endcase
    end

    logic             accept, start, b_zero, last;
    logic             sa, sb;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign accept = bus.valid_in & ~bus.flush & (state_q == S_IDLE);
    assign start  = accept & (op_mul | op_div);
    assign b_zero = (bus.operand_b == '0);
    assign last   = (cnt_q == CW'(WIDTH - 1));
    assign sa     = op_sgn & bus.operand_a[WIDTH-1];
    assign sb     = op_sgn & bus.operand_b[WIDTH-1];
    assign a_mag  = sa ? -bus.operand_a : bus.operand_a;
    assign b_mag  = sb ? -bus.operand_b : bus.operand_b;

    // Multiplier bits consumed LSB first; partial product shifts right.
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] prod_nx, mul_res;

    assign msum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                   + (b_q[cnt_q] ? {1'b0, a_q} : '0);
    assign prod_nx = {msum, prod_q[WIDTH-1:1]};
    assign mul_res = neg_q ? -prod_nx : prod_nx;

    // Dividend shifts out of a_q while quotient bits shift in.
    logic [WIDTH:0]   rsh;
    logic             ge;
    logic [WIDTH-1:0] rem_nx, quo_nx, q_res, r_res;

    assign rsh    = {rem_q, a_q[WIDTH-1]};
    assign ge     = (rsh >= {1'b0, b_q});
    assign rem_nx = ge ? WIDTH'(rsh - {1'b0, b_q}) : rsh[WIDTH-1:0];
    assign quo_nx = {a_q[WIDTH-2:0], ge};
    assign q_res  = neg_q ? -quo_nx : quo_nx;
    assign r_res  = rneg_q ? -rem_nx : rem_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op_mul)      state_d = S_MUL;
                    else if (b_zero) state_d = S_DONE;
                    else             state_d = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (bus.flush) state_d = S_IDLE;
                else if (last) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy         = (state_q == S_MUL) | (state_q == S_DIV);
        bus.stall        = start | bus.busy;
        bus.result_valid = bus.valid_in & (op_mfhi | op_mflo) & ~bus.flush;
        bus.result       = '0;
        if (bus.valid_in & op_mfhi)      bus.result = hi_q;
        else if (bus.valid_in & op_mflo) bus.result = lo_q;
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;

    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        rem_d  = rem_q;
        prod_d = prod_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (start) begin
            a_d    = a_mag;
            b_d    = b_mag;
            neg_d  = sa ^ sb;
            rneg_d = sa;
            prod_d = '0;
            rem_d  = '0;
            cnt_d  = '0;
            if (op_div && b_zero) begin
                hi_d = bus.operand_a;
                lo_d = '1;
            end
        end else if (accept && op_mthi) begin
            hi_d = bus.operand_a;
        end else if (accept && op_mtlo) begin
            lo_d = bus.operand_a;
        end
        if (state_q == S_MUL) begin
            prod_d = prod_nx;
            if (!last) cnt_d = cnt_q + CW'(1);
            if (last && !bus.flush) {hi_d, lo_d} = mul_res;
        end
        if (state_q == S_DIV) begin
            a_d   = quo_nx;
            rem_d = rem_nx;
            if (!last) cnt_d = cnt_q + CW'(1);
            if (last && !bus.flush) begin
                lo_d = q_res;
                hi_d = r_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            prod_q <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            rem_q  <= rem_d;
            prod_q <= prod_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end
endmodule
